// File: rtl/plate_pkg.sv
// Shared types and constants for the plate/day barrier controller.
// Imported by the classifier and the top-level FSM.
package plate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OPEN = 2'd2,
        DENY = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RSN_OK   = 2'd0,
        RSN_BAD  = 2'd1,
        RSN_DAY  = 2'd2,
        RSN_FULL = 2'd3
    } reason_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic is_digit(input logic [3:0] s);
        return s <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/plate_classifier.sv
// Combinational plate check: pair validity, even/odd counts,
// class and weekday admission rule.
module plate_classifier
    import plate_pkg::*;
#(
    parameter int N_CHARS = 6
) (
    input  logic [4*N_CHARS-1:0]         plate_i,
    input  logic [2:0]                   dia_i,
    output logic                         valid_o,
    output logic [$clog2(N_CHARS+1)-1:0] par_o,
    output logic [$clog2(N_CHARS+1)-1:0] impar_o,
    output logic                         class_o,
    output logic                         day_ok_o
);

    localparam int PW = $clog2(N_CHARS+1);

    logic pairs_ok;
    logic any_digit;

    always_comb begin
        pairs_ok  = 1'b1;
        any_digit = 1'b0;
        par_o     = '0;
        impar_o   = '0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (is_digit(plate_i[4*i +: 4]))
                any_digit = 1'b1;
            if (plate_i[4*i])
                impar_o = impar_o + PW'(1);
            else
                par_o = par_o + PW'(1);
        end
        for (int k = 0; k < N_CHARS/2; k++) begin
            if (is_digit(plate_i[8*k +: 4]) !=
                is_digit(plate_i[8*k+4 +: 4]))
                pairs_ok = 1'b0;
        end
    end

    assign valid_o = pairs_ok && any_digit && (dia_i != 3'd0);

    // 1 = odd class: fewer than half the symbols are even
    assign class_o = (par_o < PW'(N_CHARS/2));

    always_comb begin
        day_ok_o = 1'b0;
        if (!class_o)
            day_ok_o = dia_i[0];
        else
            day_ok_o = ((dia_i != 3'd0) && !dia_i[0]) ||
                       (dia_i == 3'd7);
    end

endmodule

// File: rtl/plate_gate_ctrl.sv
// Registered plate/day barrier controller: handshake intake, decision
// FSM, open/deny timers and car-park occupancy tracking.
module plate_gate_ctrl
    import plate_pkg::*;
#(
    parameter int N_CHARS    = 6,
    parameter int CAPACITY   = 16,
    parameter int OPEN_TICKS = 8,
    parameter int DENY_TICKS = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [4*N_CHARS-1:0]          Matricula,
    input  logic [2:0]                    Dia,
    input  logic                          plate_valid,
    output logic                          plate_ready,
    input  logic                          car_pass,
    input  logic                          car_exit,
    output logic                          Barreira,
    output logic                          MatrVal,
    output logic                          Par_Impar,
    output logic [$clog2(N_CHARS+1)-1:0]  Par,
    output logic [$clog2(N_CHARS+1)-1:0]  Impar,
    output logic                          decision_valid,
    output logic [1:0]                    reason,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full
);

    localparam int PW    = $clog2(N_CHARS+1);
    localparam int OCC_W = $clog2(CAPACITY+1);
    localparam int TMAX  = (OPEN_TICKS > DENY_TICKS) ?
                           OPEN_TICKS : DENY_TICKS;
    localparam int TW    = $clog2(TMAX+1);

    if ((N_CHARS < 2) || ((N_CHARS % 2) != 0)) begin : g_bad_n
        $error("N_CHARS must be even and at least 2");
    end

    state_e               state_q, state_d;
    logic [4*N_CHARS-1:0] plate_q;
    logic [2:0]           dia_q;
    logic [TW-1:0]        timer_q, timer_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 matrval_q;
    logic                 class_q;
    logic [PW-1:0]        par_q, impar_q;
    reason_e              reason_q, rsn_d;
    logic                 dv_q;
    logic                 barreira_q;

    logic                 c_valid;
    logic [PW-1:0]        c_par, c_impar;
    logic                 c_class;
    logic                 c_day_ok;
    logic                 inc;

    plate_classifier #(
        .N_CHARS (N_CHARS)
    ) u_cls (
        .plate_i  (plate_q),
        .dia_i    (dia_q),
        .valid_o  (c_valid),
        .par_o    (c_par),
        .impar_o  (c_impar),
        .class_o  (c_class),
        .day_ok_o (c_day_ok)
    );

    assign full = (occ_q == OCC_W'(CAPACITY));

    always_comb begin
        rsn_d = RSN_OK;
        if (!c_valid)
            rsn_d = RSN_BAD;
        else if (!c_day_ok)
            rsn_d = RSN_DAY;
        else if (full)
            rsn_d = RSN_FULL;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (plate_valid)
                    state_d = EVAL;
            end
            EVAL: begin
                timer_d = '0;
                state_d = (rsn_d == RSN_OK) ? OPEN : DENY;
            end
            OPEN: begin
                timer_d = timer_q + TW'(1);
                // a pass on the final tick still counts
                if (car_pass || (timer_q == TW'(OPEN_TICKS-1)))
                    state_d = IDLE;
            end
            DENY: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(DENY_TICKS-1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inc = (state_q == OPEN) && car_pass;

    always_comb begin
        occ_d = occ_q;
        if (inc && !car_exit && (occ_q != OCC_W'(CAPACITY)))
            occ_d = occ_q + OCC_W'(1);
        else if (car_exit && !inc && (occ_q != '0))
            occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            plate_q    <= '0;
            dia_q      <= '0;
            timer_q    <= '0;
            occ_q      <= '0;
            matrval_q  <= 1'b1;
            class_q    <= 1'b0;
            par_q      <= '0;
            impar_q    <= '0;
            reason_q   <= RSN_OK;
            dv_q       <= 1'b0;
            barreira_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            occ_q      <= occ_d;
            dv_q       <= (state_q == EVAL);
            barreira_q <= (state_d != OPEN);
            if ((state_q == IDLE) && plate_valid) begin
                plate_q <= Matricula;
                dia_q   <= Dia;
            end
            if (state_q == EVAL) begin
                matrval_q <= ~c_valid;
                class_q   <= c_class;
                par_q     <= c_par;
                impar_q   <= c_impar;
                reason_q  <= rsn_d;
            end
        end
    end

    assign plate_ready    = (state_q == IDLE);
    assign Barreira       = barreira_q;
    assign MatrVal        = matrval_q;
    assign Par_Impar      = class_q;
    assign Par            = par_q;
    assign Impar          = impar_q;
    assign decision_valid = dv_q;
    assign reason         = reason_q;
    assign occupancy      = occ_q;

endmodule
